// File: rtl/fifo_pkg.sv
// Shared constants and Gray-code helpers for the asynchronous FIFO pointer handlers.
// Helpers work on a 32-bit container; callers zero-extend in and truncate out.
package fifo_pkg;

   localparam int PTR_WIDTH_DEF = 3;
   localparam int DEPTH_DEF     = 8;
   localparam int CODE_W        = 32;

   function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Zero upper bits in the container leave the low-order result unaffected.
   function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] g);
      logic [CODE_W-1:0] b;
      b[CODE_W-1] = g[CODE_W-1];
      for (int i = CODE_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with asynchronous active-low clear; nothing sits between the stages.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_reg <= '0;
         q        <= '0;
      end else begin
         meta_reg <= d;
         q        <= meta_reg;
      end
   end

endmodule

// File: rtl/fifo_wptr_handler.sv
// Write-domain pointer and status controller: binary/Gray write pointers, full,
// almost-full, pessimistic fill level and sticky overflow for the producer.
module fifo_wptr_handler
   import fifo_pkg::*;
#(
   parameter int PTR_WIDTH = PTR_WIDTH_DEF,
   parameter int DEPTH     = DEPTH_DEF,
   parameter int AF_THRESH = 6
) (
   input  logic               wclk,
   input  logic               wrst_n,
   input  logic               w_en,
   input  logic [PTR_WIDTH:0] g_rptr_async,
   input  logic               clr_ovf,
   output logic [PTR_WIDTH:0] b_wptr,
   output logic [PTR_WIDTH:0] g_wptr,
   output logic               full,
   output logic               almost_full,
   output logic [PTR_WIDTH:0] wr_level,
   output logic               overflow
);

   localparam int PW = PTR_WIDTH + 1;
   localparam logic [PTR_WIDTH:0] AF_LEVEL = PW'(AF_THRESH);

   if (DEPTH != (1 << PTR_WIDTH)) begin : g_depth_check
      $error("fifo_wptr_handler: DEPTH must equal 2**PTR_WIDTH");
   end
   if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_af_check
      $error("fifo_wptr_handler: AF_THRESH must be within 1..DEPTH");
   end

   logic [PTR_WIDTH:0] g_rptr_sync;
   logic [PTR_WIDTH:0] b_rsync;
   logic [PTR_WIDTH:0] b_next;
   logic [PTR_WIDTH:0] g_next;
   logic [PTR_WIDTH:0] level_next;
   logic [PTR_WIDTH:0] full_pattern;
   logic               push;

   sync_2ff #(
      .WIDTH (PW)
   ) u_rptr_sync (
      .clk   (wclk),
      .rst_n (wrst_n),
      .d     (g_rptr_async),
      .q     (g_rptr_sync)
   );

   // Writes while full are dropped, so the pointer only advances on an accepted push.
   assign push    = w_en & ~full;
   assign b_next  = b_wptr + {{PTR_WIDTH{1'b0}}, push};
   assign g_next  = PW'(bin2gray(CODE_W'(b_next)));
   assign b_rsync = PW'(gray2bin(CODE_W'(g_rptr_sync)));

   // Occupancy is measured against a stale read pointer, so it can only over-report.
   assign level_next   = b_next - b_rsync;
   assign full_pattern = {~g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1], g_rptr_sync[PTR_WIDTH-2:0]};

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         b_wptr      <= '0;
         g_wptr      <= '0;
         full        <= 1'b0;
         almost_full <= 1'b0;
         wr_level    <= '0;
         overflow    <= 1'b0;
      end else begin
         b_wptr      <= b_next;
         g_wptr      <= g_next;
         full        <= (g_next == full_pattern);
         almost_full <= (level_next >= AF_LEVEL);
         wr_level    <= level_next;
         if (w_en & full) begin
            overflow <= 1'b1;
         end else if (clr_ovf) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fifo_wptr_handler.sv
// Directed bench for fifo_wptr_handler: a cycle model pushes expected outputs into a
// scoreboard queue, which is popped and compared after each clock edge.
module tb_fifo_wptr_handler;

   localparam int DEPTH = 8;
   localparam int AF    = 6;

   logic       wclk = 1'b0;
   logic       wrst_n;
   logic       w_en;
   logic [3:0] g_rptr_async;
   logic       clr_ovf;
   logic [3:0] b_wptr;
   logic [3:0] g_wptr;
   logic       full;
   logic       almost_full;
   logic [3:0] wr_level;
   logic       overflow;

   fifo_wptr_handler #(
      .PTR_WIDTH (3),
      .DEPTH     (DEPTH),
      .AF_THRESH (AF)
   ) dut (
      .wclk         (wclk),
      .wrst_n       (wrst_n),
      .w_en         (w_en),
      .g_rptr_async (g_rptr_async),
      .clr_ovf      (clr_ovf),
      .b_wptr       (b_wptr),
      .g_wptr       (g_wptr),
      .full         (full),
      .almost_full  (almost_full),
      .wr_level     (wr_level),
      .overflow     (overflow)
   );

   always #5 wclk = ~wclk;

   typedef struct {
      logic [3:0] b;
      logic [3:0] g;
      logic       full;
      logic       af;
      logic [3:0] level;
      logic       ovf;
   } exp_t;

   exp_t q[$];

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [3:0] m_b, m_s1, m_s2;
   logic       m_full, m_ovf;
   logic [3:0] prev_g, prev_b;
   int         accepted;
   logic       wrapped;

   function automatic logic [3:0] tb_g2b(input logic [3:0] g);
      logic [3:0] r;
      r[3] = g[3];
      r[2] = g[3] ^ g[2];
      r[1] = g[3] ^ g[2] ^ g[1];
      r[0] = g[3] ^ g[2] ^ g[1] ^ g[0];
      return r;
   endfunction

   function automatic logic [3:0] tb_b2g(input logic [3:0] b);
      return {b[3], b[3] ^ b[2], b[2] ^ b[1], b[1] ^ b[0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_b = 0; m_s1 = 0; m_s2 = 0; m_full = 0; m_ovf = 0;
      prev_g = 0; prev_b = 0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_b"}, b_wptr, 0);
      check({tag, "_g"}, g_wptr, 0);
      check({tag, "_full"}, full, 0);
      check({tag, "_af"}, almost_full, 0);
      check({tag, "_lvl"}, wr_level, 0);
      check({tag, "_ovf"}, overflow, 0);
   endtask

   task automatic step(input logic w, input logic [3:0] rg, input logic c);
      exp_t       e;
      logic       p;
      logic [3:0] nb, lvl;
      w_en = w; g_rptr_async = rg; clr_ovf = c;
      p   = w && !m_full;
      nb  = m_b + 4'(p);
      lvl = nb - tb_g2b(m_s2);
      e.b = nb;
      e.g = tb_b2g(nb);
      e.full  = (lvl == 4'(DEPTH));
      e.af    = (lvl >= 4'(AF));
      e.level = lvl;
      e.ovf   = (w && m_full) ? 1'b1 : (c ? 1'b0 : m_ovf);
      q.push_back(e);
      if (p) accepted++;
      m_b = nb; m_full = e.full; m_ovf = e.ovf;
      m_s2 = m_s1; m_s1 = rg;
      @(posedge wclk);
      #1;
      e = q.pop_front();
      $display("step w=%0b rg=%0h clr=%0b -> b=%0h g=%0h full=%0b af=%0b lvl=%0d ovf=%0b",
               w, rg, c, b_wptr, g_wptr, full, almost_full, wr_level, overflow);
      check("b_wptr", b_wptr, e.b);
      check("g_wptr", g_wptr, e.g);
      check("full", full, e.full);
      check("almost_full", almost_full, e.af);
      check("wr_level", wr_level, e.level);
      check("overflow", overflow, e.ovf);
      check("gray_one_bit", ($countones(g_wptr ^ prev_g) <= 1), 1);
      if (prev_b == 4'hf && b_wptr == 4'h0) wrapped = 1'b1;
      prev_g = g_wptr;
      prev_b = b_wptr;
   endtask

   initial begin
      logic [3:0] gseq [8];
      logic [3:0] rd;
      gseq = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hc};
      accepted = 0;
      wrapped  = 1'b0;
      model_reset();

      // Reset then idle
      wrst_n = 1'b0; w_en = 0; g_rptr_async = 0; clr_ovf = 0;
      @(posedge wclk);
      #1;
      check_all_zero("reset");
      wrst_n = 1'b1;
      for (int i = 0; i < 10; i++) step(0, 4'h0, 0);

      // Fill from empty
      for (int i = 0; i < 8; i++) begin
         step(1, 4'h0, 0);
         check("fill_b", b_wptr, i + 1);
         check("fill_g", g_wptr, gseq[i]);
         check("fill_af", almost_full, (i >= 5));
         check("fill_full", full, (i == 7));
      end
      check("fill_level", wr_level, 8);

      // Overflow: set, set-wins-over-clear, clear
      step(1, 4'h0, 0);
      check("ovf_hold_b", b_wptr, 8);
      check("ovf_set", overflow, 1);
      step(1, 4'h0, 1);
      check("ovf_set_wins", overflow, 1);
      step(0, 4'h0, 1);
      check("ovf_clear", overflow, 0);

      // Drain latency: read pointer 0 -> 1 takes three edges
      step(0, 4'h1, 0);
      check("drain_e1_full", full, 1);
      step(0, 4'h1, 0);
      check("drain_e2_full", full, 1);
      step(0, 4'h1, 0);
      check("drain_e3_full", full, 0);
      check("drain_e3_level", wr_level, 7);

      // Wrap: interleaved writes and read advances
      rd = 4'h1;
      accepted = 0;
      for (int i = 0; i < 600 && accepted < 40; i++) begin
         if (m_b != rd && $urandom_range(0, 1) == 1) rd = rd + 4'h1;
         step(1'($urandom_range(0, 3) != 0), tb_b2g(rd), 0);
      end
      check("wrap_accepted", (accepted >= 40), 1);
      check("wrap_seen", wrapped, 1);

      // Async reset mid-fill
      #2;
      wrst_n = 1'b0;
      #1;
      model_reset();
      @(posedge wclk);
      #1;
      wrst_n = 1'b1;
      for (int i = 0; i < 5; i++) step(1, 4'h0, 0);
      check("mid_level5", wr_level, 5);
      #2;
      wrst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      model_reset();
      #1;
      wrst_n = 1'b1;
      check("first_addr", b_wptr, 0);
      step(1, 4'h0, 0);
      check("after_release_b", b_wptr, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
